// File: rtl/pio_n_pkg.sv
// pio_n_irq shared definitions: register map, default ID code,
// synchroniser depth bounds and the byte-lane mask helper.
package pio_n_pkg;

  localparam logic [3:0] ADDR_WIDTH = 4'd0;
  localparam logic [3:0] ADDR_ID    = 4'd1;
  localparam logic [3:0] ADDR_DATA  = 4'd2;
  localparam logic [3:0] ADDR_SET   = 4'd3;
  localparam logic [3:0] ADDR_DIR   = 4'd4;
  localparam logic [3:0] ADDR_CLR   = 4'd5;
  localparam logic [3:0] ADDR_TGL   = 4'd6;
  localparam logic [3:0] ADDR_OUT   = 4'd7;
  localparam logic [3:0] ADDR_RISE  = 4'd8;
  localparam logic [3:0] ADDR_FALL  = 4'd9;
  localparam logic [3:0] ADDR_CAP   = 4'd10;
  localparam logic [3:0] ADDR_MASK  = 4'd11;

  localparam logic [31:0] DEFAULT_ID_CODE = 32'hEA680002;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 3;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    lane_mask = {{8{be[3]}}, {8{be[2]}},
                 {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Vector-wide input synchroniser with a one-cycle history register
// producing per-bit rising and falling edge strobes.
module pio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]                  prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pins};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/pio_n_irq.sv
// WIDTH-pin GPIO with atomic set/clear/toggle, byte-lane writes
// and a masked edge-capture interrupt on an Avalon-MM slave.
module pio_n_irq
  import pio_n_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] ID_CODE     = DEFAULT_ID_CODE
) (
  input  logic             csi_MCLK_clk,
  input  logic             rsi_MRST_reset,
  input  logic [3:0]       avs_gpio_address,
  input  logic [31:0]      avs_gpio_writedata,
  input  logic [3:0]       avs_gpio_byteenable,
  input  logic             avs_gpio_write,
  input  logic             avs_gpio_read,
  output logic [31:0]      avs_gpio_readdata,
  output logic             avs_gpio_waitrequest,
  output logic             ins_irq_irq,
  inout  wire  [WIDTH-1:0] coe_pio
);

  localparam int STAGES =
    (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN :
    (SYNC_STAGES > SYNC_MAX) ? SYNC_MAX : SYNC_STAGES;

  logic [WIDTH-1:0] out_reg, dir, rise_en, fall_en, cap, irq_mask;
  logic [WIDTH-1:0] out_n, dir_n, rise_n, fall_n, cap_n, mask_n;
  logic [WIDTH-1:0] sync, rise, fall;
  logic [WIDTH-1:0] bm, wm, clr;
  logic [31:0]      be_mask, rd_val;
  logic             unused_ok;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (STAGES)
  ) u_sync (
    .clk  (csi_MCLK_clk),
    .rst  (rsi_MRST_reset),
    .pins (coe_pio),
    .sync (sync),
    .rise (rise),
    .fall (fall)
  );

  assign be_mask = lane_mask(avs_gpio_byteenable);
  assign bm      = be_mask[WIDTH-1:0];
  assign wm      = avs_gpio_writedata[WIDTH-1:0] & bm;

  always_comb begin
    out_n  = out_reg;
    dir_n  = dir;
    rise_n = rise_en;
    fall_n = fall_en;
    mask_n = irq_mask;
    clr    = '0;
    if (avs_gpio_write) begin
      unique case (avs_gpio_address)
        ADDR_DATA: out_n  = (out_reg & ~bm) | wm;
        ADDR_SET:  out_n  = out_reg | wm;
        ADDR_CLR:  out_n  = out_reg & ~wm;
        ADDR_TGL:  out_n  = out_reg ^ wm;
        ADDR_DIR:  dir_n  = (dir & ~bm) | wm;
        ADDR_RISE: rise_n = (rise_en & ~bm) | wm;
        ADDR_FALL: fall_n = (fall_en & ~bm) | wm;
        ADDR_MASK: mask_n = (irq_mask & ~bm) | wm;
        ADDR_CAP:  clr    = wm;
        default: ;
      endcase
    end
    // new edges are OR-ed in after the clear so they win a collision
    cap_n = (cap & ~clr)
          | (rise & rise_en)
          | (fall & fall_en);
  end

  always_comb begin
    rd_val = '0;
    unique case (avs_gpio_address)
      ADDR_WIDTH: rd_val = 32'(WIDTH);
      ADDR_ID:    rd_val = ID_CODE;
      ADDR_DATA:  rd_val[WIDTH-1:0] = sync;
      ADDR_DIR:   rd_val[WIDTH-1:0] = dir;
      ADDR_OUT:   rd_val[WIDTH-1:0] = out_reg;
      ADDR_RISE:  rd_val[WIDTH-1:0] = rise_en;
      ADDR_FALL:  rd_val[WIDTH-1:0] = fall_en;
      ADDR_CAP:   rd_val[WIDTH-1:0] = cap;
      ADDR_MASK:  rd_val[WIDTH-1:0] = irq_mask;
      default: ;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      out_reg           <= '0;
      dir               <= '0;
      rise_en           <= '0;
      fall_en           <= '0;
      cap               <= '0;
      irq_mask          <= '0;
      avs_gpio_readdata <= '0;
      ins_irq_irq       <= 1'b0;
    end else begin
      out_reg           <= out_n;
      dir               <= dir_n;
      rise_en           <= rise_n;
      fall_en           <= fall_n;
      cap               <= cap_n;
      irq_mask          <= mask_n;
      avs_gpio_readdata <= rd_val;
      ins_irq_irq       <= |(cap & irq_mask);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign coe_pio[i] = dir[i] ? out_reg[i] : 1'bz;
  end

  assign avs_gpio_waitrequest = 1'b0;
  assign unused_ok = ^{avs_gpio_read, avs_gpio_writedata, be_mask};

endmodule

// File: tb/tb_pio_n_irq.sv
// Self-checking bench for pio_n_irq: 8-pin and 20-pin instances
// on a shared bus, read results checked through a scoreboard.
module tb_pio_n_irq;

  localparam logic [3:0] A_WIDTH = 4'd0;
  localparam logic [3:0] A_ID    = 4'd1;
  localparam logic [3:0] A_DATA  = 4'd2;
  localparam logic [3:0] A_SET   = 4'd3;
  localparam logic [3:0] A_DIR   = 4'd4;
  localparam logic [3:0] A_CLR   = 4'd5;
  localparam logic [3:0] A_TGL   = 4'd6;
  localparam logic [3:0] A_OUT   = 4'd7;
  localparam logic [3:0] A_RISE  = 4'd8;
  localparam logic [3:0] A_FALL  = 4'd9;
  localparam logic [3:0] A_CAP   = 4'd10;
  localparam logic [3:0] A_MASK  = 4'd11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = 4'hF;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  wire  [31:0] rdata8, rdata20;
  wire         wait8, wait20, irq8, irq20;
  wire  [7:0]  pins8;
  wire  [19:0] pins20;
  logic [7:0]  tb_en = '0;
  logic [7:0]  tb_val = '0;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb[$];
  logic [31:0] e, g, h;

  for (genvar i = 0; i < 8; i++) begin : g_drv
    assign pins8[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  always #5 clk = ~clk;

  pio_n_irq #(.WIDTH(8), .SYNC_STAGES(2)) u_dut (
    .csi_MCLK_clk         (clk),
    .rsi_MRST_reset       (rst),
    .avs_gpio_address     (addr),
    .avs_gpio_writedata   (wdata),
    .avs_gpio_byteenable  (be),
    .avs_gpio_write       (wr),
    .avs_gpio_read        (rd),
    .avs_gpio_readdata    (rdata8),
    .avs_gpio_waitrequest (wait8),
    .ins_irq_irq          (irq8),
    .coe_pio              (pins8)
  );

  pio_n_irq #(.WIDTH(20), .SYNC_STAGES(2)) u_w20 (
    .csi_MCLK_clk         (clk),
    .rsi_MRST_reset       (rst),
    .avs_gpio_address     (addr),
    .avs_gpio_writedata   (wdata),
    .avs_gpio_byteenable  (be),
    .avs_gpio_write       (wr),
    .avs_gpio_read        (rd),
    .avs_gpio_readdata    (rdata20),
    .avs_gpio_waitrequest (wait20),
    .ins_irq_irq          (irq20),
    .coe_pio              (pins20)
  );

  task automatic bus_write(input logic [3:0] a,
                           input logic [31:0] d,
                           input logic [3:0] b);
    addr = a; wdata = d; be = b; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; be = 4'hF;
  endtask

  task automatic bus_read(input logic [3:0] a,
                          output logic [31:0] r8,
                          output logic [31:0] r20);
    addr = a; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    r8 = rdata8; r20 = rdata20;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tb_en = 8'hFF; tb_val = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (irq8 !== 1'b0) begin
      n_bad++; $display("FAIL rst_irq got %b want 0", irq8);
    end
    n_cmp++;
    if (pins8 !== 8'h5A) begin
      n_bad++; $display("FAIL rst_pins_z got %h want 5a", pins8);
    end
    rst = 1'b0;
    sb.push_back(32'd8); sb.push_back(32'd20);
    bus_read(A_WIDTH, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL rd_width got %h want %h", g, e);
    end
    e = sb.pop_front(); n_cmp++;
    if (h !== e) begin
      n_bad++; $display("FAIL rd_width20 got %h want %h", h, e);
    end
    sb.push_back(32'hEA680002);
    bus_read(A_ID, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL rd_id got %h want %h", g, e);
    end
    sb.push_back(32'h0);
    bus_read(A_OUT, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL rd_out_rst got %h want %h", g, e);
    end
    sb.push_back(32'h5A);
    bus_read(A_DATA, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL rd_data_in got %h want %h", g, e);
    end
  endtask

  task automatic test_byte_lane();
    tb_en = 8'h00;
    bus_write(A_DIR, 32'hFFFFFFFF, 4'b0010);
    sb.push_back(32'h0000FF00); sb.push_back(32'h0);
    bus_read(A_DIR, g, h);
    e = sb.pop_front(); n_cmp++;
    if (h !== e) begin
      n_bad++; $display("FAIL lane_dir20 got %h want %h", h, e);
    end
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL lane_dir8 got %h want %h", g, e);
    end
    bus_write(A_DIR, 32'hFFFFFFFF, 4'hF);
    sb.push_back(32'h000FFFFF); sb.push_back(32'h000000FF);
    bus_read(A_DIR, g, h);
    e = sb.pop_front(); n_cmp++;
    if (h !== e) begin
      n_bad++; $display("FAIL full_dir20 got %h want %h", h, e);
    end
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL full_dir8 got %h want %h", g, e);
    end
    bus_write(A_SET, 32'h0000000F, 4'hF);
    sb.push_back(32'h0);
    bus_read(A_SET, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL wo_read got %h want %h", g, e);
    end
  endtask

  task automatic test_output();
    bus_write(A_DATA, 32'h0F, 4'hF);
    bus_write(A_SET,  32'h30, 4'hF);
    bus_write(A_CLR,  32'h01, 4'hF);
    bus_write(A_TGL,  32'h81, 4'hF);
    n_cmp++;
    if (pins8 !== 8'hBF) begin
      n_bad++; $display("FAIL out_pins got %h want bf", pins8);
    end
    sb.push_back(32'hBF);
    bus_read(A_OUT, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL out_reg got %h want %h", g, e);
    end
    wait_cycles(3);
    sb.push_back(32'hBF);
    bus_read(A_DATA, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL out_loop got %h want %h", g, e);
    end
    bus_write(A_DATA, 32'h00, 4'h0);
    bus_write(A_TGL,  32'hFF, 4'h0);
    sb.push_back(32'hBF);
    bus_read(A_OUT, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL out_nolane got %h want %h", g, e);
    end
    bus_write(A_DIR, 32'h0, 4'hF);
    tb_en = 8'hFF; tb_val = 8'h00;
    wait_cycles(4);
  endtask

  task automatic test_edge_irq();
    int lat;
    bus_write(A_RISE, 32'h04, 4'hF);
    bus_write(A_MASK, 32'h04, 4'hF);
    sb.push_back(32'h0);
    bus_read(A_CAP, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL cap_idle got %h want %h", g, e);
    end
    n_cmp++;
    if (irq8 !== 1'b0) begin
      n_bad++; $display("FAIL irq_idle got %b want 0", irq8);
    end
    tb_val[2] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (irq8 === 1'b1) lat = c;
    end
    n_cmp++;
    if (lat != 4) begin
      n_bad++; $display("FAIL irq_latency got %0d want 4", lat);
    end
    sb.push_back(32'h04);
    bus_read(A_CAP, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL cap_rise got %h want %h", g, e);
    end
    tb_val[2] = 1'b0;
    wait_cycles(5);
    sb.push_back(32'h04);
    bus_read(A_CAP, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL cap_nofall got %h want %h", g, e);
    end
    bus_write(A_FALL, 32'h08, 4'hF);
    tb_val[3] = 1'b1;
    wait_cycles(5);
    sb.push_back(32'h04);
    bus_read(A_CAP, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL cap_norise3 got %h want %h", g, e);
    end
    tb_val[3] = 1'b0;
    wait_cycles(5);
    sb.push_back(32'h0C);
    bus_read(A_CAP, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL cap_fall3 got %h want %h", g, e);
    end
    bus_write(A_CAP, 32'h08, 4'hF);
    sb.push_back(32'h04);
    bus_read(A_CAP, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL cap_w1c got %h want %h", g, e);
    end
  endtask

  task automatic test_clear_race();
    tb_val[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus_write(A_CAP, 32'h04, 4'hF);
    sb.push_back(32'h04);
    bus_read(A_CAP, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL race_cap got %h want %h", g, e);
    end
    n_cmp++;
    if (irq8 !== 1'b1) begin
      n_bad++; $display("FAIL race_irq got %b want 1", irq8);
    end
    bus_write(A_CAP, 32'h04, 4'hF);
    @(posedge clk); #1;
    n_cmp++;
    if (irq8 !== 1'b0) begin
      n_bad++; $display("FAIL clr_irq got %b want 0", irq8);
    end
    sb.push_back(32'h0);
    bus_read(A_CAP, g, h);
    e = sb.pop_front(); n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL clr_cap got %h want %h", g, e);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] regs [6];
    regs = '{A_OUT, A_DIR, A_RISE, A_FALL, A_CAP, A_MASK};
    tb_val[2] = 1'b0;
    wait_cycles(4);
    tb_val[2] = 1'b1;
    wait_cycles(6);
    bus_write(A_DATA, 32'hA5, 4'hF);
    tb_en = 8'h00;
    bus_write(A_DIR, 32'hFF, 4'hF);
    n_cmp++;
    if (pins8 !== 8'hA5) begin
      n_bad++; $display("FAIL pre_rst_pins got %h want a5", pins8);
    end
    n_cmp++;
    if (irq8 !== 1'b1) begin
      n_bad++; $display("FAIL pre_rst_irq got %b want 1", irq8);
    end
    #3;
    rst = 1'b1;
    tb_en = 8'hFF; tb_val = 8'h00;
    #1;
    n_cmp++;
    if (pins8 !== 8'h00) begin
      n_bad++; $display("FAIL arst_pins got %h want 00", pins8);
    end
    n_cmp++;
    if (irq8 !== 1'b0) begin
      n_bad++; $display("FAIL arst_irq got %b want 0", irq8);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (regs[i]) begin
      sb.push_back(32'h0);
      bus_read(regs[i], g, h);
      e = sb.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL post_rst_reg%0d got %h want %h", regs[i], g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_lane();
    test_output();
    test_edge_irq();
    test_clear_race();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
